// File: rtl/imem_responder.sv
// Instruction-memory responder: slave end of the IFU fetch handshake, one fetch in flight at a time.
// Latency: LATENCY+1 cycles request-to-response for aligned fetches, 1 cycle for misaligned ones.
// Backpressure: response held in RESP while ifu_rsp_ready=0; ifu_req_ready and mem_rd_en stay low meanwhile.
module imem_responder #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned INSTR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_rsp_err,
    output logic                  mem_rd_en,
    output logic [PC_SIZE-1:0]    mem_rd_addr,
    input  logic [INSTR_SIZE-1:0] mem_rd_data
);
    typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;

    // Dispatch lands in WAIT only for LATENCY>=2; WAIT then READ accounts for the last two cycles.
    localparam logic [3:0]         WAIT_INIT  = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = {{(PC_SIZE-2){1'b1}}, 2'b00};

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [PC_SIZE-1:0]      pc_q, pc_d;
    logic [INSTR_SIZE-1:0]   instr_q, instr_d;
    logic                    err_q, err_d;
    logic                    req_fire, rsp_fire, dispatch;
    logic                    rd_en;
    logic [PC_SIZE-1:0]      rd_addr;

    assign ifu_req_ready = !rst && (state_q == IDLE || (state_q == RESP && ifu_rsp_ready));
    assign ifu_rsp_valid = !rst && (state_q == RESP);
    assign ifu_rsp_instr = instr_q;
    assign ifu_rsp_err   = err_q;
    assign req_fire      = ifu_req_valid & ifu_req_ready;
    assign rsp_fire      = ifu_rsp_valid & ifu_rsp_ready;
    assign mem_rd_en     = rd_en & !rst;
    assign mem_rd_addr   = rd_addr & ALIGN_MASK;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        err_d    = err_q;
        rd_en    = 1'b0;
        rd_addr  = pc_q;
        dispatch = 1'b0;

        case (state_q)
            IDLE: dispatch = req_fire;
            WAIT: begin
                if (cnt_q == 4'd0) state_d = READ;
                else               cnt_d   = cnt_q - 4'd1;
            end
            READ: begin
                rd_en   = 1'b1;
                instr_d = mem_rd_data;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d  = IDLE;
                    dispatch = req_fire;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by IDLE and the back-to-back RESP path so both dispatch identically.
        if (dispatch) begin
            pc_d = ifu_req_pc;
            if (ifu_req_pc[1:0] != 2'b00) begin
                instr_d = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else if (LATENCY == 0) begin
                rd_en   = 1'b1;
                rd_addr = ifu_req_pc;
                instr_d = mem_rd_data;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (LATENCY == 1) begin
                state_d = READ;
            end else begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end
endmodule
